// File: rtl/sdc_wb_pkg.sv
// Shared definitions for the SD-controller Wishbone register path.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package sdc_wb_pkg;

    // Watchdog FSM: waiting for a request, waiting for the slave, answering the bridge.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } wb_wd_state_t;

    // Read data handed back to the bridge when the slave never answers.
    localparam logic [31:0] SDC_WB_ERR_DATA = 32'hDEAD_BEEF;

    // Increment that sticks at the top of an 8-bit range instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/wb_ack_watchdog.sv
// Wishbone pass-through that forces an error response when the slave never acks.
// Latency: ack reaches the bridge slave-latency + 2 cycles after the request; timeout after TIMEOUT_CYCLES + 2.
// Backpressure: one access in flight; a new request is accepted only in IDLE with no ack on the bus.
module wb_ack_watchdog
    import sdc_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = SDC_WB_ERR_DATA
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [7:0]  s_wb_addr_i,
    input  logic [31:0] s_wb_dat_i,
    input  logic [3:0]  s_wb_sel_i,
    input  logic        s_wb_we_i,
    input  logic        s_wb_cyc_i,
    input  logic        s_wb_stb_i,
    output logic [31:0] s_wb_dat_o,
    output logic        s_wb_ack_o,

    output logic [7:0]  m_wb_addr_o,
    output logic [31:0] m_wb_dat_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,

    output logic        timeout_o,
    output logic [7:0]  timeout_addr_o,
    output logic [7:0]  timeout_cnt_o
);

    // Wait-counter value seen on the last cycle the slave is allowed to answer.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    wb_wd_state_t state;
    logic [7:0]   wait_cnt;
    logic         req_start;

    // The bridge keeps cyc/stb up during the cycle our ack is visible; that
    // same request must not be taken a second time, hence the ack gate.
    assign req_start = s_wb_cyc_i & s_wb_stb_i & ~s_wb_ack_o;

    // Request/response FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= 8'd0;
            m_wb_addr_o    <= 8'd0;
            m_wb_dat_o     <= 32'd0;
            m_wb_sel_o     <= 4'd0;
            m_wb_we_o      <= 1'b0;
            m_wb_cyc_o     <= 1'b0;
            m_wb_stb_o     <= 1'b0;
            s_wb_dat_o     <= 32'd0;
            s_wb_ack_o     <= 1'b0;
            timeout_o      <= 1'b0;
            timeout_addr_o <= 8'd0;
            timeout_cnt_o  <= 8'd0;
        end else begin
            // Single-cycle strobes fall back unless re-asserted below.
            s_wb_ack_o <= 1'b0;
            timeout_o  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_start) begin
                        m_wb_addr_o <= s_wb_addr_i;
                        m_wb_dat_o  <= s_wb_dat_i;
                        m_wb_sel_o  <= s_wb_sel_i;
                        m_wb_we_o   <= s_wb_we_i;
                        m_wb_cyc_o  <= 1'b1;
                        m_wb_stb_o  <= 1'b1;
                        wait_cnt    <= 8'd0;
                        state       <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (!s_wb_cyc_i) begin
                        // Bridge gave up: release the slave bus silently.
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (m_wb_ack_i) begin
                        // A real ack beats a coincident timeout.
                        s_wb_dat_o <= m_wb_dat_i;
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        state      <= ST_RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        s_wb_dat_o     <= ERR_DATA;
                        m_wb_cyc_o     <= 1'b0;
                        m_wb_stb_o     <= 1'b0;
                        timeout_o      <= 1'b1;
                        timeout_addr_o <= m_wb_addr_o;
                        timeout_cnt_o  <= sat_inc8(timeout_cnt_o);
                        state          <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    s_wb_ack_o <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ack_watchdog.sv
// Directed bench for wb_ack_watchdog with a transaction-level expectation model.
// Latency: n/a (bench).
// Backpressure: bench bridge holds cyc/stb until it samples the ack.
module tb_wb_ack_watchdog;

    localparam int          T       = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
    localparam logic [31:0] JUNK    = 32'h0BAD_0BAD;

    logic        clk;
    logic        reset;
    logic [7:0]  s_wb_addr_i;
    logic [31:0] s_wb_dat_i;
    logic [3:0]  s_wb_sel_i;
    logic        s_wb_we_i;
    logic        s_wb_cyc_i;
    logic        s_wb_stb_i;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_ack_o;
    logic [7:0]  m_wb_addr_o;
    logic [31:0] m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_i;
    logic        timeout_o;
    logic [7:0]  timeout_addr_o;
    logic [7:0]  timeout_cnt_o;

    wb_ack_watchdog #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .s_wb_addr_i(s_wb_addr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_sel_i(s_wb_sel_i),
        .s_wb_we_i(s_wb_we_i), .s_wb_cyc_i(s_wb_cyc_i), .s_wb_stb_i(s_wb_stb_i),
        .s_wb_dat_o(s_wb_dat_o), .s_wb_ack_o(s_wb_ack_o),
        .m_wb_addr_o(m_wb_addr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
        .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i),
        .timeout_o(timeout_o), .timeout_addr_o(timeout_addr_o), .timeout_cnt_o(timeout_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after the most recent edge.
    bit          model_on = 0;
    logic        exp_mcyc, exp_sack, exp_to, exp_mwe;
    logic [31:0] exp_sdat, exp_mdat;
    logic [7:0]  exp_maddr, exp_taddr;
    logic [3:0]  exp_msel;
    int          n_to;

    function automatic logic [7:0] exp_cnt();
        return (n_to > 255) ? 8'd255 : 8'(n_to);
    endfunction

    task automatic model_clear();
        exp_mcyc = 0; exp_sack = 0; exp_to = 0; exp_mwe = 0;
        exp_sdat = '0; exp_mdat = '0; exp_maddr = '0; exp_taddr = '0; exp_msel = '0;
        n_to = 0;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_cyc", m_wb_cyc_o, exp_mcyc);
            chk("m_stb", m_wb_stb_o, exp_mcyc);
            chk("s_ack", s_wb_ack_o, exp_sack);
            chk("timeout", timeout_o, exp_to);
            chk("timeout_cnt", timeout_cnt_o, exp_cnt());
            chk("timeout_addr", timeout_addr_o, exp_taddr);
            chk("s_dat", s_wb_dat_o, exp_sdat);
            chk("m_addr", m_wb_addr_o, exp_maddr);
            chk("m_dat", m_wb_dat_o, exp_mdat);
            chk("m_sel", m_wb_sel_o, exp_msel);
            chk("m_we", m_wb_we_o, exp_mwe);
        end
    end

    // One bridge access. lat = edge index at which the slave acks (0 = never),
    // abort_at / reset_at = edge index of bridge abort / reset (0 = none),
    // late_ack = slave acks this many edges after a timeout (0 = never).
    // ack_edge = edge index at which the bridge samples s_wb_ack_o (-1 = none).
    task automatic run_txn(input logic [7:0] addr, input logic [31:0] wdat, input logic [3:0] sel,
                           input logic we, input int lat, input logic [31:0] rdata,
                           input int abort_at, input int reset_at, input int late_ack,
                           output int ack_edge, output logic [31:0] ack_dat);
        bit tmo;
        int r;
        int kend;
        tmo  = (lat == 0) || (lat > T);
        r    = tmo ? T : lat;
        kend = r + 2;
        if (abort_at > 0) kend = abort_at;
        if (reset_at > 0) kend = reset_at;
        ack_edge = -1;
        ack_dat  = '0;
        s_wb_addr_i = addr; s_wb_dat_i = wdat; s_wb_sel_i = sel; s_wb_we_i = we;
        for (int k = 0; k <= kend; k++) begin
            s_wb_cyc_i = !(abort_at > 0 && k >= abort_at);
            s_wb_stb_i = s_wb_cyc_i;
            reset      = (reset_at > 0 && k == reset_at);
            m_wb_ack_i = (lat > 0 && k == lat) || (tmo && late_ack > 0 && k == r + late_ack);
            m_wb_dat_i = m_wb_ack_i ? rdata : JUNK;
            @(posedge clk);
            #1;
            if (reset) begin
                model_clear();
            end else if (abort_at > 0 && k == abort_at) begin
                exp_mcyc = 0;
            end else begin
                if (k == 0) begin
                    exp_maddr = addr; exp_mdat = wdat; exp_msel = sel; exp_mwe = we;
                end
                exp_mcyc = (k < r);
                exp_sack = (k == r + 1);
                exp_to   = tmo && (k == r);
                if (k == r) begin
                    if (tmo) begin
                        exp_sdat  = ERR_VAL;
                        exp_taddr = addr;
                        n_to++;
                    end else begin
                        exp_sdat = rdata;
                    end
                end
            end
            if (s_wb_ack_o === 1'b1) begin
                ack_edge = k + 1;
                ack_dat  = s_wb_dat_o;
            end
        end
        s_wb_cyc_i = 0; s_wb_stb_i = 0; reset = 0; m_wb_ack_i = 0; m_wb_dat_i = JUNK;
        @(posedge clk);
        #1;
        exp_mcyc = 0; exp_sack = 0; exp_to = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int          ae;
        logic [31:0] ad;

        reset = 1; s_wb_addr_i = '0; s_wb_dat_i = '0; s_wb_sel_i = '0; s_wb_we_i = 0;
        s_wb_cyc_i = 0; s_wb_stb_i = 0; m_wb_dat_i = JUNK; m_wb_ack_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_cyc", m_wb_cyc_o, 32'd0);
        chk("rst s_ack", s_wb_ack_o, 32'd0);
        chk("rst timeout", timeout_o, 32'd0);
        chk("rst cnt", timeout_cnt_o, 32'd0);
        chk("rst taddr", timeout_addr_o, 32'd0);
        chk("rst s_dat", s_wb_dat_o, 32'd0);
        chk("rst m_addr", m_wb_addr_o, 32'd0);
        model_clear();
        model_on = 1;
        reset = 0;
        @(posedge clk);
        #1;

        // Read 0x24, slave answers on the third wait cycle.
        run_txn(8'h24, 32'h0, 4'hF, 1'b0, 3, 32'h1234_5678, 0, 0, 0, ae, ad);
        chk("read ack edge", 32'(ae), 32'd5);
        chk("read ack data", ad, 32'h1234_5678);

        // Write 0x08, slave silent: error response.
        run_txn(8'h08, 32'hA5A5_0001, 4'hF, 1'b1, 0, 32'h0, 0, 0, 0, ae, ad);
        chk("tmo ack edge", 32'(ae), 32'd18);
        chk("tmo ack data", ad, 32'hDEAD_BEEF);
        chk("tmo addr", timeout_addr_o, 32'h08);
        chk("tmo cnt", timeout_cnt_o, 32'd1);
        chk("tmo m_cyc", m_wb_cyc_o, 32'd0);

        // Ack on the last allowed wait cycle wins over the timeout.
        run_txn(8'h30, 32'h0, 4'h3, 1'b0, 16, 32'hCAFE_0016, 0, 0, 0, ae, ad);
        chk("edge ack edge", 32'(ae), 32'd18);
        chk("edge ack data", ad, 32'hCAFE_0016);
        chk("edge cnt", timeout_cnt_o, 32'd1);

        // One cycle too late: timeout, then the stray ack lands in RESP.
        run_txn(8'h31, 32'h0, 4'hF, 1'b0, 17, 32'h1111_2222, 0, 0, 0, ae, ad);
        chk("late17 data", ad, 32'hDEAD_BEEF);
        chk("late17 cnt", timeout_cnt_o, 32'd2);

        // Timeout followed by an ack two cycles later, then a quick normal read.
        run_txn(8'h44, 32'h0, 4'hF, 1'b0, 0, 32'h7777_7777, 0, 0, 2, ae, ad);
        chk("late2 addr", timeout_addr_o, 32'h44);
        run_txn(8'h48, 32'h0, 4'h1, 1'b0, 1, 32'h0000_BEEF, 0, 0, 0, ae, ad);
        chk("next ack edge", 32'(ae), 32'd3);
        chk("next ack data", ad, 32'h0000_BEEF);
        chk("next cnt", timeout_cnt_o, 32'd3);

        // Bridge abandons the access mid-wait: no ack back.
        run_txn(8'h50, 32'h5555_AAAA, 4'hC, 1'b1, 0, 32'h0, 5, 0, 0, ae, ad);
        chk("abort no ack", 32'(ae), 32'hFFFF_FFFF);

        // Long run of timeouts drives the counter into saturation.
        for (int i = 0; i < 300; i++) begin
            run_txn(8'(i), 32'(i), 4'hF, 1'b1, 0, 32'h0, 0, 0, 0, ae, ad);
        end
        chk("sat cnt", timeout_cnt_o, 32'd255);
        chk("sat addr", timeout_addr_o, 32'(8'(299)));

        // Reset in the middle of a wait clears everything.
        run_txn(8'h66, 32'h1234_ABCD, 4'hF, 1'b1, 0, 32'h0, 0, 6, 0, ae, ad);
        chk("rst-mid no ack", 32'(ae), 32'hFFFF_FFFF);
        chk("rst-mid m_cyc", m_wb_cyc_o, 32'd0);
        chk("rst-mid cnt", timeout_cnt_o, 32'd0);
        chk("rst-mid m_addr", m_wb_addr_o, 32'd0);
        chk("rst-mid s_dat", s_wb_dat_o, 32'd0);

        // Normal service after reset.
        run_txn(8'h24, 32'h0, 4'hF, 1'b0, 2, 32'h8765_4321, 0, 0, 0, ae, ad);
        chk("post-rst ack edge", 32'(ae), 32'd4);
        chk("post-rst data", ad, 32'h8765_4321);

        model_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
